systolic_row_engine: RTL



---
 rtl/systolic_row_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_row_engine.sv
// One row of N_MACS weight-stationary MAC lanes fed by a skewed activation chain.
// Results are held behind a res_valid/res_ready handshake until accepted.
module systolic_row_engine #(
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int K_MAX  = 16,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_weight,
    input  logic                    start_compute,
    input  logic                    clear_all,
    input  logic [2:0]              mode,
    input  logic [KW-1:0]           k_len,
    input  logic                    w_in_valid,
    output logic                    w_in_ready,
    input  logic [W-1:0]            w_in_data,
    input  logic                    a_in_valid,
    output logic                    a_in_ready,
    input  logic [W-1:0]            a_in_data,
    output logic [N_MACS*ACC_W-1:0] acc_out,
    output logic [N_MACS-1:0]       valid_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy
);
    localparam int WCW = (N_MACS > 1) ? $clog2(N_MACS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_RESULT
    } state_e;

    state_e                  state_q, state_d;
    logic [WCW-1:0]          wcnt_q;
    logic [KW-1:0]           cnt_q, keff_q, k_in;
    logic [1:0]              mode_q;
    logic signed [W-1:0]     w_q       [N_MACS];
    logic signed [W-1:0]     ch_data_q [N_MACS];
    logic [N_MACS-1:0]       ch_vld_q, ch_last_q, last_q, valid_q;
    logic signed [ACC_W-1:0] acc_q     [N_MACS];
    logic signed [ACC_W-1:0] acc_d     [N_MACS];
    logic signed [2*W-1:0]   prod      [N_MACS];
    logic signed [ACC_W:0]   sum       [N_MACS];
    logic                    w_acc, a_acc, a_last, start_c, res_acc;

    assign k_in      = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign w_acc     = w_in_valid && w_in_ready;
    assign a_acc     = a_in_valid && a_in_ready;
    assign a_last    = a_acc && (cnt_q == keff_q - KW'(1));
    assign start_c   = (state_q == S_IDLE) && !start_weight && start_compute;
    assign res_valid = (state_q == S_RESULT) && (&valid_q);
    assign res_acc   = res_valid && res_ready;
    assign busy      = (state_q != S_IDLE);
    assign valid_out = valid_q;

    always_comb begin
        state_d    = state_q;
        w_in_ready = 1'b0;
        a_in_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_weight) begin
                    state_d = S_LOAD_W;
                end else if (start_compute) begin
                    state_d = (k_in == '0) ? S_RESULT : S_COMPUTE;
                end
            end
            S_LOAD_W: begin
                w_in_ready = 1'b1;
                if (w_in_valid && wcnt_q == WCW'(N_MACS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                a_in_ready = (cnt_q < keff_q);
                if (a_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_q[N_MACS-1]) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_all) begin
            state_d = S_IDLE;
        end
    end

    // One guard bit above ACC_W detects overflow for the saturating mode.
    always_comb begin
        for (int i = 0; i < N_MACS; i++) begin
            prod[i] = (2*W)'(w_q[i]) * (2*W)'(ch_data_q[i]);
            sum[i]  = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(prod[i]);
            acc_d[i] = sum[i][ACC_W-1:0];
            if (mode_q[0] && (sum[i][ACC_W] != sum[i][ACC_W-1])) begin
                acc_d[i] = sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_comb begin
        acc_out = '0;
        for (int i = 0; i < N_MACS; i++) begin
            acc_out[i*ACC_W +: ACC_W] =
                (mode_q[1] && acc_q[i][ACC_W-1]) ? '0 : acc_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            cnt_q     <= '0;
            keff_q    <= '0;
            mode_q    <= '0;
            ch_vld_q  <= '0;
            ch_last_q <= '0;
            last_q    <= '0;
            valid_q   <= '0;
            for (int i = 0; i < N_MACS; i++) begin
                w_q[i]       <= '0;
                ch_data_q[i] <= '0;
                acc_q[i]     <= '0;
            end
        end else if (clear_all) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            cnt_q     <= '0;
            ch_vld_q  <= '0;
            ch_last_q <= '0;
            last_q    <= '0;
            valid_q   <= '0;
            for (int i = 0; i < N_MACS; i++) begin
                ch_data_q[i] <= '0;
                acc_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            if (w_acc) begin
                w_q[wcnt_q] <= w_in_data;
                wcnt_q <= (wcnt_q == WCW'(N_MACS - 1)) ? '0 : wcnt_q + WCW'(1);
            end
            ch_data_q[0] <= a_in_data;
            ch_vld_q[0]  <= a_acc;
            ch_last_q[0] <= a_last;
            for (int i = 1; i < N_MACS; i++) begin
                ch_data_q[i] <= ch_data_q[i-1];
                ch_vld_q[i]  <= ch_vld_q[i-1];
                ch_last_q[i] <= ch_last_q[i-1];
            end
            if (a_acc) begin
                cnt_q <= cnt_q + KW'(1);
            end
            // last_q marks the lane whose final update just landed.
            last_q  <= ch_vld_q & ch_last_q;
            valid_q <= valid_q | last_q;
            for (int i = 0; i < N_MACS; i++) begin
                if (ch_vld_q[i]) begin
                    acc_q[i] <= acc_d[i];
                end
            end
            if (start_c) begin
                mode_q <= mode[1:0];
                keff_q <= k_in;
                cnt_q  <= '0;
                if (!mode[2]) begin
                    for (int i = 0; i < N_MACS; i++) begin
                        acc_q[i] <= '0;
                    end
                end
                if (k_in == '0) begin
                    valid_q <= '1;
                end
            end
            if (res_acc) begin
                valid_q <= '0;
            end
        end
    end
endmodule
